alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Command-side initiator for the 4-bit gate-level ALU.
- Accepts an operation (select plus A/B/C operands) over a valid/ready command port and drives the ALU inputs from registers.
- Waits a fixed settle time to cover the ALU's gate propagation delay, then captures RegOut/Carryout.
- Returns the captured result over a valid/ready response port. One operation in flight at a time.

Parameters:
- WIDTH, 4: operand/result width; must match the ALU.
- SETTLE_CYCLES, 3: clock edges between driving the ALU inputs and capturing its outputs; legal range 1..15.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_select  input  3  ALU operation code.
- cmd_a, cmd_b, cmd_c  input  WIDTH  operands.
- alu_select  output  3  drives ALU Select.
- alu_a, alu_b, alu_c  output  WIDTH  drive ALU A/B/C.
- alu_regout  input  WIDTH  from ALU RegOut.
- alu_carryout  input  1  from ALU Carryout.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes result.
- rsp_result  output  WIDTH  captured ALU result.
- rsp_carry  output  1  captured carry, masked.
- rsp_select  output  3  echo of the operation code.
- busy  output  1  high whenever state is not IDLE.
- mismatch  output  1  sticky checker flag (see Optional Feature).

Behaviour:
- Reset (reset=0, async): state IDLE. All alu_*, rsp_*, busy and mismatch are 0. Settle counter is 0. cmd_ready is 1 (cmd_ready = state==IDLE).
- Reset mid-operation: the in-flight command is dropped; no response is produced.
- IDLE:
  - On an edge with cmd_valid & cmd_ready, register cmd_* onto alu_* at that edge (call it T0).
  - Load the counter with SETTLE_CYCLES and go to SETTLE.
  - cmd_valid low: stay in IDLE; alu_* hold their last values (they do not return to 0).
- SETTLE:
  - cmd_ready=0 and alu_* are held stable.
  - The counter decrements each edge.
  - On the edge where the counter equals 1 (edge T0+SETTLE_CYCLES), capture alu_regout into rsp_result, carry into rsp_carry and alu_select into rsp_select. Set rsp_valid=1 and go to RESP.
- RESP:
  - rsp_valid and rsp_* are held stable until the edge with rsp_valid & rsp_ready.
  - At that edge rsp_valid goes to 0, state goes to IDLE, and cmd_ready becomes 1 after the edge.
  - rsp_ready may be low indefinitely. Commands presented during SETTLE/RESP are not accepted, because cmd_ready=0.
- Throughput: with rsp_ready held high, consecutive commands are accepted at T0, T0+SETTLE_CYCLES+2, and so on.
- Carry masking: rsp_carry = alu_carryout only for select 001 (A+B+C) and 101 (rotate); it is 0 for all other selects.
- Ignored inputs: cmd_b is ignored for selects 000, 101, 110 and 111 but is still driven to alu_b. cmd_c is used only by 001 and 101.
- Opcode map (reference model and checker):
  - 000: ~A.
  - 001: (A+B+C) mod 2^WIDTH; carry = (A+B+C) ≥ 2^WIDTH.
  - 010: A&B.
  - 011: A|B.
  - 100: A^B.
  - 101: {A[WIDTH-2:0], C[0]}; carry = A[WIDTH-1].
  - 110: all 0.
  - 111: all 1.

Optional Feature:
- Macro: ALU_SEQ_CHECK_EN.
- Defined:
  - An internal reference model computes the expected result/carry from the registered alu_* values.
  - At the capture edge, mismatch is set to 1 if rsp_result or the masked rsp_carry would differ from the expected value.
  - mismatch is sticky and is cleared only by reset.
- Undefined: no model logic is built; mismatch is tied to 0.
- Port list is identical in both builds.

Test Plan:
- Reset held low with random inputs -> all outputs 0, cmd_ready=1, busy=0; after release, the first command is accepted on the first edge.
- Select=010, A=0xC, B=0xA; ALU model returns 0x8 -> alu_* update at T0, rsp_valid rises exactly 3 edges later, rsp_result=0x8, rsp_carry=0, rsp_select=010.
- Select=001, A=9, B=8, C=1; model returns 0x2 with carry 1 -> rsp_result=0x2, rsp_carry=1. Then select=011 with alu_carryout forced to 1 -> rsp_carry=0.
- rsp_ready held low 10 cycles while cmd_valid is held high with a new command -> rsp_valid and rsp_* stable, cmd_ready=0, alu_* unchanged. After rsp_ready pulses, the new command is accepted one edge after the handshake.
- Reset asserted 2 edges into SETTLE -> outputs go to 0 immediately, rsp_valid never rises; the next command completes normally.
- ALU_SEQ_CHECK_EN defined; select=000, A=0x5, model returns 0x7 (expected 0xA) -> mismatch=1 at the capture edge, still 1 after a following correct command, 0 only after reset.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives the gate-level ALU from registers, waits SETTLE_CYCLES, returns the captured result.
// Optional checker (mismatch flag) is enabled by defining ALU_SEQ_CHECK_EN.
module alu_op_sequencer #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_select,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [WIDTH-1:0] cmd_c,
    output logic [2:0]       alu_select,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [WIDTH-1:0] alu_c,
    input  logic [WIDTH-1:0] alu_regout,
    input  logic             alu_carryout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic [2:0]       rsp_select,
    output logic             busy,
    output logic             mismatch
);
    typedef enum logic [1:0] {IDLE, SETTLE, RESP} stateType;
    stateType state, nextState;
    logic [3:0] settleCount;
    logic accept, capture, rspDone, carryOp;

    assign accept  = cmd_valid && state == IDLE;
    assign capture = state == SETTLE && settleCount == 4'd1;
    assign rspDone = rsp_valid && rsp_ready;
    assign carryOp = alu_select == 3'b001 || alu_select == 3'b101;

    always_ff @(posedge clock or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= nextState;

    always_comb
        nextState = accept ? SETTLE : capture ? RESP : rspDone ? IDLE : state;

    always_comb begin
        cmd_ready = state == IDLE;
        busy      = state != IDLE;
        rsp_valid = state == RESP;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            settleCount <= '0;
            alu_select  <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_c       <= '0;
            rsp_result  <= '0;
            rsp_carry   <= 1'b0;
            rsp_select  <= '0;
        end else begin
            if (accept) begin
                settleCount <= 4'(SETTLE_CYCLES);
                alu_select  <= cmd_select;
                alu_a       <= cmd_a;
                alu_b       <= cmd_b;
                alu_c       <= cmd_c;
            end else if (state == SETTLE) begin
                settleCount <= settleCount - 4'd1;
            end
            if (capture) begin
                rsp_result <= alu_regout;
                rsp_carry  <= carryOp & alu_carryout;
                rsp_select <= alu_select;
            end
        end
    end

`ifdef ALU_SEQ_CHECK_EN
    logic [WIDTH-1:0] expResult;
    logic             expCarry;

    always_comb begin
        expResult = '0;
        expCarry  = 1'b0;
        case (alu_select)
            3'b000: expResult = ~alu_a;
            3'b001: {expCarry, expResult} = {1'b0, alu_a} + {1'b0, alu_b} + {1'b0, alu_c};
            3'b010: expResult = alu_a & alu_b;
            3'b011: expResult = alu_a | alu_b;
            3'b100: expResult = alu_a ^ alu_b;
            3'b101: {expCarry, expResult} = {alu_a, alu_c[0]};
            3'b110: expResult = '0;
            default: expResult = '1;
        endcase
    end

    // Sticky until reset so a single bad capture is never lost.
    always_ff @(posedge clock or negedge reset)
        if (!reset) mismatch <= 1'b0;
        else if (capture && (alu_regout != expResult || (carryOp & alu_carryout) != expCarry))
            mismatch <= 1'b1;
`else
    assign mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed + random scoreboard bench for alu_op_sequencer with a behavioural ALU model.
module tb_alu_op_sequencer;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [2:0] cmd_select = '0;
    logic [3:0] cmd_a = '0, cmd_b = '0, cmd_c = '0;
    logic [2:0] alu_select;
    logic [3:0] alu_a, alu_b, alu_c, alu_regout;
    logic       alu_carryout;
    logic       rsp_valid, rsp_ready = 1'b0;
    logic [3:0] rsp_result;
    logic       rsp_carry;
    logic [2:0] rsp_select;
    logic       busy, mismatch;

    typedef struct packed {logic [2:0] sel; logic [3:0] result; logic carry;} rspType;
    rspType expQ[$];
    int nAsserts = 0, nFails = 0;

    logic       overrideEn = 1'b0, forceCarry = 1'b0;
    logic [3:0] overrideVal = '0;
    logic [4:0] modelOut;

`ifdef ALU_SEQ_CHECK_EN
    localparam logic expMismatch = 1'b1;
`else
    localparam logic expMismatch = 1'b0;
`endif

    always #5 clock = ~clock;

    alu_op_sequencer dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_select(cmd_select),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c),
        .alu_select(alu_select), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .alu_regout(alu_regout), .alu_carryout(alu_carryout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_select(rsp_select),
        .busy(busy), .mismatch(mismatch)
    );

    function automatic logic [4:0] refModel(input logic [2:0] sel, input logic [3:0] a, b, c);
        case (sel)
            3'b000: return {1'b0, ~a};
            3'b001: return {1'b0, a} + {1'b0, b} + {1'b0, c};
            3'b010: return {1'b0, a & b};
            3'b011: return {1'b0, a | b};
            3'b100: return {1'b0, a ^ b};
            3'b101: return {a, c[0]};
            3'b110: return 5'h00;
            default: return 5'h0F;
        endcase
    endfunction

    // Behavioural ALU with hooks to corrupt its result or force its carry.
    assign modelOut     = refModel(alu_select, alu_a, alu_b, alu_c);
    assign alu_regout   = overrideEn ? overrideVal : modelOut[3:0];
    assign alu_carryout = forceCarry | modelOut[4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nAsserts++;
        assert (obs === expv) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic driveCmd(input logic [2:0] sel, input logic [3:0] a, b, c);
        cmd_valid = 1'b1; cmd_select = sel; cmd_a = a; cmd_b = b; cmd_c = c;
    endtask

    task automatic acceptCmd(output int waited);
        logic [4:0] m;
        waited = 0;
        while (!cmd_ready && waited < 50) begin @(negedge clock); waited++; end
        check("cmdReadyTimeout", 32'(waited < 50), 1);
        @(posedge clock);
        m = refModel(cmd_select, cmd_a, cmd_b, cmd_c);
        expQ.push_back({cmd_select, overrideEn ? overrideVal : m[3:0],
                        (cmd_select == 3'b001 || cmd_select == 3'b101) & (m[4] | forceCarry)});
        @(negedge clock);
        check("aluDriven", {alu_select, alu_a, alu_b, alu_c}, {cmd_select, cmd_a, cmd_b, cmd_c});
        check("busyAfterAccept", {busy, cmd_ready}, 2'b10);
        cmd_valid = 1'b0;
    endtask

    task automatic sendCmd(input logic [2:0] sel, input logic [3:0] a, b, c);
        int w;
        @(negedge clock);
        driveCmd(sel, a, b, c);
        acceptCmd(w);
    endtask

    task automatic waitRsp();
        int edges = 0;
        while (!rsp_valid && edges < 40) begin @(posedge clock); edges++; @(negedge clock); end
        check("rspLatency", edges, 3);
    endtask

    task automatic recvRsp();
        rspType e;
        check("queueNotEmpty", 32'(expQ.size() > 0), 1);
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check("rspValid", rsp_valid, 1);
            check("rspSelect", rsp_select, e.sel);
            check("rspResult", rsp_result, e.result);
            check("rspCarry", rsp_carry, e.carry);
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
        check("rspDropped", {rsp_valid, cmd_ready, busy}, 3'b010);
    endtask

    initial begin
        int w;
        logic [31:0] snapRsp, snapAlu;
        // Reset held with random activity on every input
        repeat (4) begin
            @(negedge clock);
            cmd_valid = 1'($urandom); cmd_select = 3'($urandom);
            cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_c = 4'($urandom);
            rsp_ready = 1'($urandom); overrideEn = 1'b1; overrideVal = 4'($urandom);
            forceCarry = 1'($urandom);
        end
        check("resetAlu", {alu_select, alu_a, alu_b, alu_c}, 0);
        check("resetRsp", {rsp_valid, rsp_result, rsp_carry, rsp_select}, 0);
        check("resetCtl", {cmd_ready, busy, mismatch}, 3'b100);
        overrideEn = 1'b0; forceCarry = 1'b0; rsp_ready = 1'b0;
        @(negedge clock);
        driveCmd(3'b010, 4'hC, 4'hA, 4'h3);
        reset = 1'b1;
        acceptCmd(w);
        check("firstEdgeAccept", w, 0);
        waitRsp();
        check("andResult", {rsp_result, rsp_carry, rsp_select}, {4'h8, 1'b0, 3'b010});
        recvRsp();
        // Add with carry, then OR with a spurious ALU carry that must be masked
        sendCmd(3'b001, 4'h9, 4'h8, 4'h1);
        waitRsp();
        check("addResult", {rsp_result, rsp_carry}, {4'h2, 1'b1});
        recvRsp();
        forceCarry = 1'b1;
        sendCmd(3'b011, 4'h3, 4'h4, 4'h0);
        waitRsp();
        check("orCarryMasked", rsp_carry, 0);
        recvRsp();
        sendCmd(3'b101, 4'hB, 4'h0, 4'h1);
        waitRsp();
        check("rotateResult", {rsp_result, rsp_carry}, {4'h7, 1'b1});
        recvRsp();
        forceCarry = 1'b0;
        // Back-pressure with a pending command
        sendCmd(3'b100, 4'h6, 4'h3, 4'h0);
        waitRsp();
        driveCmd(3'b111, 4'h1, 4'h2, 4'h3);
        snapRsp = {rsp_valid, rsp_select, rsp_result, rsp_carry};
        snapAlu = {alu_select, alu_a, alu_b, alu_c};
        repeat (10) begin
            @(negedge clock);
            check("holdRsp", {rsp_valid, rsp_select, rsp_result, rsp_carry}, snapRsp);
            check("holdAlu", {alu_select, alu_a, alu_b, alu_c}, snapAlu);
            check("holdNotReady", cmd_ready, 0);
        end
        recvRsp();
        acceptCmd(w);
        check("acceptAfterHandshake", w, 0);
        waitRsp();
        recvRsp();
        // Reset two edges into SETTLE drops the operation
        sendCmd(3'b011, 4'h5, 4'hA, 4'h0);
        expQ.delete(expQ.size() - 1);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check("midResetAlu", {alu_select, alu_a, alu_b, alu_c}, 0);
        check("midResetCtl", {rsp_valid, busy, cmd_ready}, 3'b001);
        repeat (5) begin @(negedge clock); check("noRspAfterReset", rsp_valid, 0); end
        reset = 1'b1;
        sendCmd(3'b110, 4'hF, 4'hF, 4'hF);
        waitRsp();
        recvRsp();
        // Corrupted ALU result drives the sticky checker flag
        overrideEn = 1'b1; overrideVal = 4'h7;
        sendCmd(3'b000, 4'h5, 4'h0, 4'h0);
        waitRsp();
        check("mismatchSet", mismatch, 32'(expMismatch));
        recvRsp();
        overrideEn = 1'b0;
        sendCmd(3'b000, 4'h5, 4'h0, 4'h0);
        waitRsp();
        recvRsp();
        check("mismatchSticky", mismatch, 32'(expMismatch));
        reset = 1'b0;
        #1 check("mismatchCleared", mismatch, 0);
        @(negedge clock);
        reset = 1'b1;
        // Random operations with random consumer delay
        repeat (12) begin
            sendCmd(3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            waitRsp();
            repeat ($urandom_range(0, 3)) @(negedge clock);
            recvRsp();
        end
        check("mismatchClean", mismatch, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule
